// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 encodings, FSM states and
// the access-legality helpers used by the stage and any future cache.
package mem_pkg;

  localparam int LANES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_t;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  // Width is carried in funct3[1:0] for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (f3[1:0] == 2'b01) mis = off[0];
    else if (f3[1:0] == 2'b10) mis = (off != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: shifts the read word down to the addressed
// byte and applies sign or zero extension according to funct3.
module load_align
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [1:0]       offset,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = shifted;
    case (funct3)
      F3_B:  data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_H:  data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_BU: data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      F3_HU: data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory handshake, store lane formatting, load alignment
// and the MEM/WB register. Byte-lane logic assumes WIDTH = 32.
module mem_stage
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_result_in,
  input  logic [WIDTH-1:0] write_data_in,
  input  logic [4:0]       rd_in,
  input  logic [2:0]       funct3_in,
  input  logic             regWrite_in,
  input  logic             memtoReg_in,
  input  logic             memRead_in,
  input  logic             memWrite_in,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ready,
  output logic             stall_out,
  output logic [WIDTH-1:0] read_data_out,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [4:0]       rd_out,
  output logic             regWrite_out,
  output logic             memtoReg_out,
  output logic             fault_out
);

  mem_state_t       state;
  logic             access;
  logic             fault;
  logic             f3_illegal;
  logic             misaligned;
  logic [1:0]       offset;
  logic [LANES-1:0] be_base;
  logic [WIDTH-1:0] load_data;

  assign offset     = alu_result_in[1:0];
  assign access     = memRead_in | memWrite_in;
  assign f3_illegal = (memRead_in & ~load_f3_legal(funct3_in)) |
                      (memWrite_in & ~store_f3_legal(funct3_in));
  assign misaligned = access & is_misaligned(funct3_in, offset);
  assign fault      = (memRead_in & memWrite_in) | f3_illegal | misaligned;

  // The request is a pure function of state, so it never chains combinationally.
  assign stall_out = ((state == IDLE) & access & ~fault) |
                     ((state == ACCESS) & ~dmem_ready);
  assign dmem_req  = (state == ACCESS);
  assign dmem_we   = (state == ACCESS) & memWrite_in;
  assign dmem_addr = {alu_result_in[WIDTH-1:2], 2'b00};

  always_comb begin
    dmem_wdata = write_data_in;
    be_base    = '0;
    case (funct3_in)
      F3_B: begin
        dmem_wdata = {LANES{write_data_in[7:0]}};
        be_base    = 4'b0001;
      end
      F3_H: begin
        dmem_wdata = {2{write_data_in[15:0]}};
        be_base    = 4'b0011;
      end
      F3_W: begin
        dmem_wdata = write_data_in;
        be_base    = 4'b1111;
      end
      default: begin
        dmem_wdata = write_data_in;
        be_base    = '0;
      end
    endcase
  end

  assign dmem_be = (memWrite_in & ~fault) ? (be_base << offset) : '0;

  load_align #(
    .WIDTH(WIDTH)
  ) u_load_align (
    .rdata (dmem_rdata),
    .offset(offset),
    .funct3(funct3_in),
    .data  (load_data)
  );

  // A stalled cycle leaves a bubble; data fields keep their old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      read_data_out  <= '0;
      alu_result_out <= '0;
      rd_out         <= '0;
      regWrite_out   <= 1'b0;
      memtoReg_out   <= 1'b0;
      fault_out      <= 1'b0;
    end else begin
      case (state)
        IDLE:   if (access && !fault) state <= ACCESS;
        ACCESS: if (dmem_ready) state <= IDLE;
      endcase

      if (stall_out) begin
        regWrite_out <= 1'b0;
        memtoReg_out <= 1'b0;
        fault_out    <= 1'b0;
      end else begin
        alu_result_out <= alu_result_in;
        rd_out         <= rd_in;
        memtoReg_out   <= memtoReg_in;
        regWrite_out   <= regWrite_in & ~fault;
        fault_out      <= fault;
        read_data_out  <= (memRead_in && !fault) ? load_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage with a byte-array memory model.
module tb_mem_stage;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw, mtr, mr, mw;
    int          lat;
  } op_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rw, mtr, flt;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    int          lat;
  } req_t;

  logic        clk, rst;
  logic [31:0] alu_result_in, write_data_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        regWrite_in, memtoReg_in, memRead_in, memWrite_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic        stall_out;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  rd_out;
  logic        regWrite_out, memtoReg_out, fault_out;

  wb_t  wb_q[$];
  req_t req_q[$];
  logic [7:0] ref_mem [0:1023];
  logic [7:0] dut_mem [0:1023];
  int checks = 0;
  int passes = 0;
  bit stop_mon = 0;

  mem_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .rd_in(rd_in), .funct3_in(funct3_in),
    .regWrite_in(regWrite_in), .memtoReg_in(memtoReg_in),
    .memRead_in(memRead_in), .memWrite_in(memWrite_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall_out(stall_out), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .rd_out(rd_out),
    .regWrite_out(regWrite_out), .memtoReg_out(memtoReg_out),
    .fault_out(fault_out)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] aborting");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic int accessSize(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  // Little-endian read from the reference memory, extended as the load requires.
  function automatic logic [31:0] refLoad(input int a, input int size, input bit sgn);
    logic [31:0] v;
    v = 0;
    for (int k = 0; k < size; k++) v |= 32'(ref_mem[a + k]) << (8 * k);
    if (sgn && size < 4 && v[8 * size - 1]) v |= 32'hFFFF_FFFF << (8 * size);
    return v;
  endfunction

  function automatic op_t mkOp(input logic [31:0] addr, input logic [31:0] wd,
                               input logic [4:0] rd, input logic [2:0] f3,
                               input logic rw, input logic mtr, input logic mr,
                               input logic mw, input int lat);
    op_t op;
    op.addr = addr; op.wd = wd; op.rd = rd; op.f3 = f3;
    op.rw = rw; op.mtr = mtr; op.mr = mr; op.mw = mw; op.lat = lat;
    return op;
  endfunction

  function automatic op_t randOp();
    op_t op;
    logic [2:0] lf [5];
    int kind, sz;
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    kind = $urandom_range(0, 9);
    op = mkOp($urandom, $urandom, 5'($urandom), 3'($urandom), 0, 0, 0, 0,
              $urandom_range(0, 4));
    case (kind)
      0, 1:    op.rw = 1'($urandom);
      2, 3, 4: begin op.mr = 1; op.rw = 1; op.mtr = 1; op.f3 = lf[$urandom_range(0, 4)]; end
      5, 6:    begin op.mw = 1; op.f3 = 3'($urandom_range(0, 2)); end
      7:       begin op.mr = 1'($urandom); op.mw = ~op.mr; op.rw = op.mr; end
      8:       begin op.mr = 1; op.mw = 1; end
      default: op.rw = 0;
    endcase
    if (op.mr || op.mw) begin
      op.addr = 32'($urandom_range(0, 1023));
      sz = accessSize(op.f3);
      if ($urandom_range(0, 3) != 0) op.addr = op.addr - (op.addr % sz);
    end
    return op;
  endfunction

  // Present one op, record what should come out, and hold it until accepted.
  task automatic applyStimulus(input op_t op);
    int size, off, a, cnt, exp_stall;
    bit ld_ok, st_ok, acc, flt, s;
    wb_t w;
    req_t r;
    alu_result_in = op.addr; write_data_in = op.wd; rd_in = op.rd;
    funct3_in = op.f3; regWrite_in = op.rw; memtoReg_in = op.mtr;
    memRead_in = op.mr; memWrite_in = op.mw;

    size  = accessSize(op.f3);
    ld_ok = op.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    st_ok = op.f3 inside {3'd0, 3'd1, 3'd2};
    acc   = op.mr || op.mw;
    flt   = acc && ((op.mr && op.mw) || (op.mr && !ld_ok) || (op.mw && !st_ok) ||
                    (op.addr % size != 0));
    off   = int'(op.addr % 4);
    a     = int'(op.addr[9:0]);

    w.alu = op.addr; w.rd = op.rd; w.mtr = op.mtr;
    w.rw = op.rw && !flt; w.flt = flt; w.rdata = 0;
    if (acc && !flt) begin
      r.addr = op.addr & ~32'd3; r.we = op.mw; r.lat = op.lat;
      for (int i = 0; i < 4; i++) begin
        r.be[i] = op.mw && (i >= off) && (i < off + size);
        r.wdata[8*i +: 8] = op.wd[8*(i % size) +: 8];
      end
      if (op.mr) w.rdata = refLoad(a, size, op.f3 inside {3'd0, 3'd1});
      if (op.mw) for (int k = 0; k < size; k++) ref_mem[a + k] = op.wd[8*k +: 8];
      req_q.push_back(r);
    end
    wb_q.push_back(w);

    exp_stall = (acc && !flt) ? op.lat + 1 : 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      s = stall_out;
      @(posedge clk);
      if (!s) break;
      cnt++;
      if (cnt > 200) begin
        $display("[TB] FAIL stall_timeout: got %0d cycles expected %0d", cnt, exp_stall);
        $fatal(1, "[TB] aborting");
      end
    end
    checkOutput("stall_cycles", cnt, exp_stall);
    #1;
  endtask

  // Memory responder: checks each request against the scoreboard and
  // answers after the latency chosen for that op.
  initial begin
    req_t cur;
    int cnt, a;
    bit busy;
    busy = 0; cnt = 0;
    dmem_ready = 0; dmem_rdata = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        busy = 0; dmem_ready = 0;
      end else begin
        if (dmem_ready) begin dmem_ready = 0; busy = 0; end
        if (dmem_req && !busy) begin
          if (req_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_req: got req addr 0x%08h expected none", dmem_addr);
          end else begin
            cur = req_q.pop_front();
            checkOutput("req_addr", dmem_addr, cur.addr);
            checkOutput("req_we", 32'(dmem_we), 32'(cur.we));
            checkOutput("req_be", 32'(dmem_be), 32'(cur.be));
            if (cur.we) checkOutput("req_wdata", dmem_wdata, cur.wdata);
            busy = 1; cnt = cur.lat;
          end
        end
        if (busy) begin
          if (cnt == 0) begin
            a = int'(dmem_addr[9:0]);
            dmem_rdata = {dut_mem[a+3], dut_mem[a+2], dut_mem[a+1], dut_mem[a]};
            if (dmem_we)
              for (int i = 0; i < 4; i++)
                if (dmem_be[i]) dut_mem[a + i] = dmem_wdata[8*i +: 8];
            dmem_ready = 1;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // MEM/WB monitor: decides at each negedge what the next edge must produce.
  initial begin
    int pend;
    wb_t w;
    pend = 0;
    forever begin
      @(negedge clk);
      case (pend)
        1: begin
          if (wb_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL wb_underflow: got writeback expected none");
          end else begin
            w = wb_q.pop_front();
            checkOutput("wb_rd", 32'(rd_out), 32'(w.rd));
            checkOutput("wb_alu", alu_result_out, w.alu);
            checkOutput("wb_regwrite", 32'(regWrite_out), 32'(w.rw));
            checkOutput("wb_memtoreg", 32'(memtoReg_out), 32'(w.mtr));
            checkOutput("wb_fault", 32'(fault_out), 32'(w.flt));
            checkOutput("wb_rdata", read_data_out, w.rdata);
          end
        end
        2: begin
          checkOutput("bubble_regwrite", 32'(regWrite_out), 0);
          checkOutput("bubble_memtoreg", 32'(memtoReg_out), 0);
          checkOutput("bubble_fault", 32'(fault_out), 0);
        end
        3: begin
          checkOutput("rst_rdata", read_data_out, 0);
          checkOutput("rst_alu", alu_result_out, 0);
          checkOutput("rst_rd", 32'(rd_out), 0);
          checkOutput("rst_ctrl", {29'd0, regWrite_out, memtoReg_out, fault_out}, 0);
        end
        default: ;
      endcase
      if (rst) pend = 3;
      else if (stall_out) pend = 2;
      else pend = 1;
      if (stop_mon) pend = 0;
    end
  end

  initial begin
    op_t nop;
    logic [7:0] b;
    nop = mkOp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      ref_mem[i] = b; dut_mem[i] = b;
    end
    ref_mem[512] = 8'h01; ref_mem[513] = 8'h7F; ref_mem[514] = 8'hFF; ref_mem[515] = 8'h80;
    dut_mem[512] = 8'h01; dut_mem[513] = 8'h7F; dut_mem[514] = 8'hFF; dut_mem[515] = 8'h80;

    rst = 1;
    alu_result_in = 0; write_data_in = 0; rd_in = 0; funct3_in = 0;
    regWrite_in = 0; memtoReg_in = 0; memRead_in = 0; memWrite_in = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    checkOutput("rst_dmem_req", 32'(dmem_req), 0);

    applyStimulus(mkOp(32'h100, 32'hDEADBEEF, 5'd0, 3'd2, 0, 0, 0, 1, 3));
    applyStimulus(mkOp(32'h203, 0, 5'd7, 3'd0, 1, 1, 1, 0, 1));
    applyStimulus(mkOp(32'h203, 0, 5'd8, 3'd4, 1, 1, 1, 0, 0));
    applyStimulus(mkOp(32'h006, 32'h0000ABCD, 5'd0, 3'd1, 0, 0, 0, 1, 0));
    applyStimulus(mkOp(32'h102, 0, 5'd9, 3'd2, 1, 1, 1, 0, 0));
    applyStimulus(mkOp(32'h42, 0, 5'd5, 3'd0, 1, 0, 0, 0, 0));

    // Abandon a load mid-access with reset, then confirm the stage recovers.
    alu_result_in = 32'h104; funct3_in = 3'd2; rd_in = 5'd3;
    regWrite_in = 1; memtoReg_in = 1; memRead_in = 1; memWrite_in = 0;
    req_q.push_back('{addr: 32'h104, wdata: 0, we: 0, be: 0, lat: 50});
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("abort_req_active", 32'(dmem_req), 1);
    rst = 1;
    alu_result_in = 0; rd_in = 0; funct3_in = 0;
    regWrite_in = 0; memtoReg_in = 0; memRead_in = 0;
    @(posedge clk); #1;
    rst = 0;
    checkOutput("abort_req_dropped", 32'(dmem_req), 0);
    checkOutput("abort_stall_dropped", 32'(stall_out), 0);
    applyStimulus(nop);
    applyStimulus(mkOp(32'h100, 0, 5'd4, 3'd2, 1, 1, 1, 0, 2));

    for (int n = 0; n < 300; n++) applyStimulus(randOp());
    applyStimulus(nop);

    @(negedge clk);
    #2;
    stop_mon = 1;
    checkOutput("req_queue_drained", req_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
